// File: rtl/debounce_scheduler.sv
// debounce_scheduler: prescaled sample strobe plus a round-robin
// debouncer servicing one button per clock through one datapath.
module debounce_scheduler #(
  parameter int NUM_BTN  = 5,
  parameter int TICK_DIV = 100000,
  parameter int DEPTH    = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [NUM_BTN-1:0] btn_in,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic               tick,
  output logic               busy
);

  localparam int CW = $clog2(TICK_DIV);
  localparam int IW = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [NUM_BTN-1:0] meta;
  logic [NUM_BTN-1:0] sync;
  logic [CW-1:0]      cnt;
  logic [1:0]         state;
  logic [IW-1:0]      idx;
  logic [DEPTH-1:0]   hist [NUM_BTN];
  logic [DEPTH-1:0]   nxt;
  logic               last;

  assign busy = (state != IDLE);
  assign last = (idx == IW'(NUM_BTN - 1));
  assign nxt  = {hist[idx][DEPTH-2:0], sync[idx]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      sync <= '0;
    end else begin
      meta <= btn_in;
      sync <= meta;
    end
  end

  // Holding the count at zero while disabled makes the first strobe
  // after re-enable land a full period later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (!enable) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == CW'(TICK_DIV - 1)) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + CW'(1);
      tick <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      btn_level   <= '0;
      btn_press   <= '0;
      btn_release <= '0;
      for (int i = 0; i < NUM_BTN; i++) begin
        hist[i] <= '0;
      end
    end else begin
      btn_press   <= '0;
      btn_release <= '0;
      unique case (state)
        IDLE: begin
          if (tick) begin
            state <= SCAN;
            idx   <= '0;
          end
        end
        SCAN: begin
          hist[idx] <= nxt;
          if (&nxt && !btn_level[idx]) begin
            btn_level[idx] <= 1'b1;
            btn_press[idx] <= 1'b1;
          end else if (~|nxt && btn_level[idx]) begin
            btn_level[idx]   <= 1'b0;
            btn_release[idx] <= 1'b1;
          end
          if (last) begin
            state <= DONE;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          idx   <= '0;
        end
        default: begin
          state <= IDLE;
          idx   <= '0;
        end
      endcase
    end
  end

  // A strobe outside IDLE means TICK_DIV is too small for NUM_BTN.
  tick_overrun: assert property (
    @(posedge clk) disable iff (!rst_n) tick |-> (state == IDLE)
  ) else $error("tick while scan busy");

endmodule

// File: tb/tb_debounce_scheduler.sv
// tb_debounce_scheduler: table-driven vectors with an expectation
// queue, plus hand sequences for timing corner cases.
module tb_debounce_scheduler;

  localparam int NB = 3;
  localparam int TD = 8;
  localparam int DP = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic [NB-1:0] btn_in = '0;
  logic [NB-1:0] btn_level;
  logic [NB-1:0] btn_press;
  logic [NB-1:0] btn_release;
  logic          tick;
  logic          busy;

  int vectors = 0;
  int miscompares = 0;

  int prs_cnt [NB];
  int rel_cnt [NB];

  typedef struct {
    logic [NB-1:0] btn;
    int            ticks;
    logic [NB-1:0] lvl;
    logic [NB-1:0] prs;
    logic [NB-1:0] rel;
  } vec_t;

  typedef struct {
    logic [NB-1:0] lvl;
    logic [NB-1:0] prs;
    logic [NB-1:0] rel;
  } exp_t;

  exp_t exp_q[$];
  vec_t vt[13];

  debounce_scheduler #(
    .NUM_BTN (NB),
    .TICK_DIV(TD),
    .DEPTH   (DP)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .btn_in     (btn_in),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .tick       (tick),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    for (int b = 0; b < NB; b++) begin
      prs_cnt[b] = 0;
      rel_cnt[b] = 0;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      for (int b = 0; b < NB; b++) begin
        prs_cnt[b] += int'(btn_press[b]);
        rel_cnt[b] += int'(btn_release[b]);
      end
      if ((btn_press & btn_release) != '0) begin
        miscompares++;
        $display("FAIL overlap press=%b release=%b",
                 btn_press, btn_release);
      end
    end
  end

  task automatic check(input string nm,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic wait_tick();
    for (int i = 0; i < 4 * TD; i++) begin
      @(negedge clk);
      if (tick) return;
    end
    miscompares++;
    $display("FAIL tick_timeout got none expected tick");
  endtask

  task automatic scan_end();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 4 * TD; i++) begin
      @(negedge clk);
      if (busy) seen = 1'b1;
      else if (seen) return;
    end
    miscompares++;
    $display("FAIL scan_timeout got busy=%b expected fall", busy);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 4 * TD; i++) begin
      if (!busy) return;
      @(negedge clk);
    end
    miscompares++;
    $display("FAIL idle_timeout got busy=1 expected 0");
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int            p0 [NB];
    int            r0 [NB];
    int            dp;
    int            dr;
    logic [NB-1:0] gp;
    logic [NB-1:0] gr;
    bit            multi;
    exp_t          e;
    exp_q.push_back('{lvl: v.lvl, prs: v.prs, rel: v.rel});
    for (int b = 0; b < NB; b++) begin
      p0[b] = prs_cnt[b];
      r0[b] = rel_cnt[b];
    end
    btn_in = v.btn;
    repeat (v.ticks) begin
      wait_tick();
      scan_end();
    end
    e = exp_q.pop_front();
    multi = 1'b0;
    for (int b = 0; b < NB; b++) begin
      dp = prs_cnt[b] - p0[b];
      dr = rel_cnt[b] - r0[b];
      gp[b] = (dp != 0);
      gr[b] = (dr != 0);
      if (dp > 1 || dr > 1) multi = 1'b1;
    end
    vectors++;
    if (btn_level !== e.lvl || gp !== e.prs
        || gr !== e.rel || multi) begin
      miscompares++;
      $display("FAIL %s got lvl=%b prs=%b rel=%b multi=%b expected lvl=%b prs=%b rel=%b",
               nm, btn_level, gp, gr, multi, e.lvl, e.prs, e.rel);
    end
  endtask

  initial begin
    int            per;
    int            nb;
    int            nt;
    logic [NB-1:0] seq [4];

    vt[0]  = '{3'b000, 2, 3'b000, 3'b000, 3'b000};
    vt[1]  = '{3'b010, 3, 3'b000, 3'b000, 3'b000};
    vt[2]  = '{3'b010, 1, 3'b010, 3'b010, 3'b000};
    vt[3]  = '{3'b000, 3, 3'b010, 3'b000, 3'b000};
    vt[4]  = '{3'b000, 1, 3'b000, 3'b000, 3'b010};
    vt[5]  = '{3'b001, 1, 3'b000, 3'b000, 3'b000};
    vt[6]  = '{3'b000, 1, 3'b000, 3'b000, 3'b000};
    vt[7]  = '{3'b001, 1, 3'b000, 3'b000, 3'b000};
    vt[8]  = '{3'b001, 1, 3'b000, 3'b000, 3'b000};
    vt[9]  = '{3'b000, 1, 3'b000, 3'b000, 3'b000};
    vt[10] = '{3'b001, 3, 3'b000, 3'b000, 3'b000};
    vt[11] = '{3'b001, 1, 3'b001, 3'b001, 3'b000};
    vt[12] = '{3'b000, 4, 3'b000, 3'b000, 3'b001};

    rst_n  = 1'b0;
    enable = 1'b1;
    btn_in = '1;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          32'({btn_level, btn_press, btn_release, tick, busy}), 32'd0);

    btn_in = '0;
    rst_n  = 1'b1;
    wait_tick();
    per = 0;
    nb  = 0;
    for (int i = 1; i <= 5 * TD; i++) begin
      @(negedge clk);
      if (busy) nb++;
      if (tick) begin
        per = i;
        break;
      end
    end
    check("tick_period", 32'(per), 32'(TD));
    check("busy_cycles", 32'(nb), 32'(NB + 1));
    scan_end();

    for (int i = 0; i < 13; i++) begin
      run_vec(vt[i], $sformatf("vec%0d", i));
    end

    btn_in = 3'b111;
    repeat (3) begin
      wait_tick();
      scan_end();
    end
    seq[0] = 3'b000;
    seq[1] = 3'b001;
    seq[2] = 3'b010;
    seq[3] = 3'b100;
    wait_tick();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("simul_press%0d", k),
            32'(btn_press), 32'(seq[k]));
    end
    wait_idle();
    check("simul_level", 32'(btn_level), 32'b111);

    wait_tick();
    nb = 0;
    @(negedge clk);
    if (busy) nb++;
    @(negedge clk);
    if (busy) nb++;
    enable = 1'b0;
    for (int i = 0; i < 4 * TD; i++) begin
      @(negedge clk);
      if (busy) nb++;
      else break;
    end
    check("scan_completes", 32'(nb), 32'(NB + 1));
    btn_in = '0;
    nt = 0;
    repeat (50) begin
      @(negedge clk);
      if (tick) nt++;
    end
    check("disabled_ticks", 32'(nt), 32'd0);
    check("disabled_level", 32'(btn_level), 32'b111);
    enable = 1'b1;
    per = 0;
    for (int i = 1; i <= 5 * TD; i++) begin
      @(negedge clk);
      if (tick) begin
        per = i;
        break;
      end
    end
    check("reenable_latency", 32'(per), 32'(TD));
    scan_end();
    run_vec('{3'b101, 3, 3'b101, 3'b000, 3'b010}, "to_101");

    wait_tick();
    @(negedge clk);
    @(negedge clk);
    check("pre_reset_level", 32'(btn_level), 32'b101);
    rst_n = 1'b0;
    #1;
    check("midscan_reset",
          32'({btn_level, btn_press, btn_release, tick, busy}), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_vec('{3'b101, 3, 3'b000, 3'b000, 3'b000}, "rebuild3");
    run_vec('{3'b101, 1, 3'b101, 3'b101, 3'b000}, "rebuild4");

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
